mod_deser: RTL and testbench

//  Stream deserializer: packs RATIO narrow beats (DWIDTH bits) into one wide

---
 rtl/mod_deser.sv | 115 +++++++++++
 tb/tb_mod_deser.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_deser.sv
// Stream deserializer: packs RATIO narrow beats into one wide word, with
// early packet close on s_last (unwritten slices padded, flagged by m_keep).
//
// state    | meaning
// ST_EMPTY | no output word held, upstream may fill freely
// ST_HOLD  | output word valid, waiting for m_ready
module mod_deser #(
   parameter int                DWIDTH    = 8,
   parameter int                RATIO     = 4,
   parameter bit                MSB_FIRST = 1'b1,
   parameter logic [DWIDTH-1:0] PAD       = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DWIDTH-1:0]         s_data,
   input  logic                      s_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DWIDTH*RATIO-1:0]   m_data,
   output logic [RATIO-1:0]          m_keep,
   output logic                      m_last,
   output logic [15:0]               word_cnt
);

   localparam int KW = $clog2(RATIO);
   localparam int WW = DWIDTH * RATIO;

   typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [WW-1:0]     acc_q, acc_d, merged;
   logic [RATIO-1:0]  wr_q, wr_d, wr_merged;
   logic [WW-1:0]     m_data_d;
   logic [RATIO-1:0]  m_keep_d;
   logic              m_last_d;
   logic [15:0]       word_cnt_d;
   logic [KW-1:0]     slice;
   logic              accept, close, out_take;

   assign m_valid  = (state_q == ST_HOLD);
   assign s_ready  = rst_n && (!m_valid || m_ready);
   assign accept   = s_valid && s_ready;
   assign out_take = m_valid && m_ready;
   assign slice    = MSB_FIRST ? (KW'(RATIO - 1) - k_q) : k_q;
   assign close    = accept && ((k_q == KW'(RATIO - 1)) || s_last);

   always_comb begin
      merged     = acc_q;
      wr_merged  = wr_q;
      state_d    = state_q;
      k_d        = k_q;
      acc_d      = acc_q;
      wr_d       = wr_q;
      m_data_d   = m_data;
      m_keep_d   = m_keep;
      m_last_d   = m_last;
      word_cnt_d = word_cnt;

      for (int i = 0; i < RATIO; i++) begin
         if (KW'(i) == slice) begin
            merged[i*DWIDTH +: DWIDTH] = s_data;
            wr_merged[i]               = 1'b1;
         end
      end

      if (out_take) begin
         word_cnt_d = word_cnt + 16'd1;
         state_d    = ST_EMPTY;
      end

      if (close) begin
         state_d  = ST_HOLD;
         k_d      = '0;
         acc_d    = {RATIO{PAD}};
         wr_d     = '0;
         m_keep_d = wr_merged;
         m_last_d = s_last;
         // Padding is chosen by the write mask, so the accumulator's
         // post-reset contents never leak into a short word.
         for (int i = 0; i < RATIO; i++) begin
            m_data_d[i*DWIDTH +: DWIDTH] = wr_merged[i] ? merged[i*DWIDTH +: DWIDTH] : PAD;
         end
      end else if (accept) begin
         k_d   = k_q + KW'(1);
         acc_d = merged;
         wr_d  = wr_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         k_q      <= '0;
         acc_q    <= '0;
         wr_q     <= '0;
         m_data   <= '0;
         m_keep   <= '0;
         m_last   <= 1'b0;
         word_cnt <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         wr_q     <= wr_d;
         m_data   <= m_data_d;
         m_keep   <= m_keep_d;
         m_last   <= m_last_d;
         word_cnt <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_mod_deser.sv
// Directed bench for mod_deser: one MSB-first instance padding with EE and one
// LSB-first instance padding with 00, driven in lockstep.
module tb_mod_deser;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        m_ready;

   logic        s_ready_a, m_valid_a, m_last_a;
   logic [31:0] m_data_a;
   logic [3:0]  m_keep_a;
   logic [15:0] word_cnt_a;

   logic        s_ready_b, m_valid_b, m_last_b;
   logic [31:0] m_data_b;
   logic [3:0]  m_keep_b;
   logic [15:0] word_cnt_b;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   mod_deser #(.DWIDTH(8), .RATIO(4), .MSB_FIRST(1'b1), .PAD(8'hEE)) u_msb (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
      .s_data(s_data), .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready),
      .m_data(m_data_a), .m_keep(m_keep_a), .m_last(m_last_a), .word_cnt(word_cnt_a)
   );

   mod_deser #(.DWIDTH(8), .RATIO(4), .MSB_FIRST(1'b0), .PAD(8'h00)) u_lsb (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b),
      .s_data(s_data), .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready),
      .m_data(m_data_b), .m_keep(m_keep_b), .m_last(m_last_b), .word_cnt(word_cnt_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_take();
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      step();
      exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      n_checks++;
      if ({m_valid_a, m_valid_b, word_cnt_a, word_cnt_b} !== {2'b00, 16'(exp_cnt), 16'(exp_cnt)}) begin
         $display("FAIL take_count got v=%b%b cnt=%h/%h exp v=00 cnt=%h",
                  m_valid_a, m_valid_b, word_cnt_a, word_cnt_b, 16'(exp_cnt));
         n_fail++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
      step();
      step();
      n_checks++;
      if ({m_valid_a, m_data_a, m_keep_a, m_last_a, word_cnt_a, s_ready_a} !== 55'd0) begin
         $display("FAIL reset_outputs got v=%b d=%h k=%b l=%b c=%h r=%b exp all zero",
                  m_valid_a, m_data_a, m_keep_a, m_last_a, word_cnt_a, s_ready_a);
         n_fail++;
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({s_ready_a, s_ready_b, m_valid_a} !== 3'b110) begin
         $display("FAIL reset_release got rdy=%b%b v=%b exp rdy=11 v=0", s_ready_a, s_ready_b, m_valid_a);
         n_fail++;
      end
      exp_cnt = 0;
   endtask

   task automatic test_full_word();
      logic [7:0] beats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = beats[i]; s_last = 1'b0;
         step();
      end
      n_checks++;
      if ({m_valid_a, m_data_a, m_keep_a, m_last_a} !== {1'b1, 32'h11223344, 4'hF, 1'b0}) begin
         $display("FAIL full_msb got v=%b d=%h k=%h l=%b exp v=1 d=11223344 k=f l=0",
                  m_valid_a, m_data_a, m_keep_a, m_last_a);
         n_fail++;
      end
      n_checks++;
      if ({m_valid_b, m_data_b, m_keep_b, m_last_b} !== {1'b1, 32'h44332211, 4'hF, 1'b0}) begin
         $display("FAIL full_lsb got v=%b d=%h k=%h l=%b exp v=1 d=44332211 k=f l=0",
                  m_valid_b, m_data_b, m_keep_b, m_last_b);
         n_fail++;
      end
      idle_take();
   endtask

   task automatic test_short_packet();
      m_ready = 1'b1;
      s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0;
      step();
      s_data = 8'hBB; s_last = 1'b1;
      step();
      n_checks++;
      if ({m_valid_a, m_data_a, m_keep_a, m_last_a} !== {1'b1, 32'hAABBEEEE, 4'b1100, 1'b1}) begin
         $display("FAIL short_msb got v=%b d=%h k=%b l=%b exp v=1 d=aabbeeee k=1100 l=1",
                  m_valid_a, m_data_a, m_keep_a, m_last_a);
         n_fail++;
      end
      n_checks++;
      if ({m_data_b, m_keep_b, m_last_b} !== {32'h0000BBAA, 4'b0011, 1'b1}) begin
         $display("FAIL short_lsb got d=%h k=%b l=%b exp d=0000bbaa k=0011 l=1",
                  m_data_b, m_keep_b, m_last_b);
         n_fail++;
      end
      idle_take();
   endtask

   task automatic test_single_beat();
      m_ready = 1'b1;
      s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
      step();
      n_checks++;
      if ({m_valid_a, m_data_a, m_keep_a, m_last_a, m_data_b, m_keep_b} !==
          {1'b1, 32'h5AEEEEEE, 4'b1000, 1'b1, 32'h0000005A, 4'b0001}) begin
         $display("FAIL single_beat got v=%b d=%h k=%b l=%b lsb d=%h k=%b exp 1 5aeeeeee 1000 1 / 0000005a 0001",
                  m_valid_a, m_data_a, m_keep_a, m_last_a, m_data_b, m_keep_b);
         n_fail++;
      end
      idle_take();
   endtask

   task automatic test_hold();
      logic [7:0] beats [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = beats[i]; s_last = 1'b0;
         step();
      end
      s_data = 8'hFF; s_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({s_ready_a, m_valid_a, m_data_a, m_keep_a, m_last_a} !== {2'b01, 32'hA1A2A3A4, 4'hF, 1'b0}) begin
            $display("FAIL hold_cycle%0d got rdy=%b v=%b d=%h k=%h l=%b exp rdy=0 v=1 d=a1a2a3a4 k=f l=0",
                     i, s_ready_a, m_valid_a, m_data_a, m_keep_a, m_last_a);
            n_fail++;
         end
         step();
      end
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      #1;
      n_checks++;
      if (s_ready_a !== 1'b1) begin
         $display("FAIL hold_release_ready got %b exp 1", s_ready_a);
         n_fail++;
      end
      idle_take();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_word;
      m_ready = 1'b1;
      exp_word = '0;
      for (int w = 0; w < 8; w++) begin
         for (int b = 0; b < 4; b++) begin
            s_valid = 1'b1; s_last = 1'b0; s_data = 8'((w << 4) + b + 1);
            exp_word = {exp_word[23:0], s_data};
            #1;
            n_checks++;
            if (s_ready_a !== 1'b1) begin
               $display("FAIL b2b_ready w%0d b%0d got %b exp 1", w, b, s_ready_a);
               n_fail++;
            end
            step();
            n_checks++;
            if (m_valid_a !== (b == 3)) begin
               $display("FAIL b2b_valid w%0d b%0d got %b exp %b", w, b, m_valid_a, (b == 3));
               n_fail++;
            end
            if (b == 3) begin
               n_checks++;
               if ({m_data_a, m_keep_a} !== {exp_word, 4'hF}) begin
                  $display("FAIL b2b_data w%0d got %h k=%h exp %h k=f", w, m_data_a, m_keep_a, exp_word);
                  n_fail++;
               end
            end
         end
      end
      exp_cnt = exp_cnt + 7;
      idle_take();
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b1;
      s_valid = 1'b1; s_last = 1'b0; s_data = 8'hC1;
      step();
      s_data = 8'hC2;
      step();
      rst_n = 1'b0; s_valid = 1'b0;
      step();
      n_checks++;
      if ({m_valid_a, m_data_a, m_keep_a, m_last_a, word_cnt_a, s_ready_a} !== 55'd0) begin
         $display("FAIL midreset_outputs got v=%b d=%h k=%b l=%b c=%h r=%b exp all zero",
                  m_valid_a, m_data_a, m_keep_a, m_last_a, word_cnt_a, s_ready_a);
         n_fail++;
      end
      rst_n = 1'b1;
      exp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_last = 1'b0; s_data = 8'(8'hD1 + i);
         step();
      end
      n_checks++;
      if ({m_valid_a, m_data_a, m_keep_a, m_data_b, m_keep_b} !==
          {1'b1, 32'hD1D2D3D4, 4'hF, 32'hD4D3D2D1, 4'hF}) begin
         $display("FAIL midreset_fresh got v=%b d=%h k=%h lsb d=%h k=%h exp 1 d1d2d3d4 f / d4d3d2d1 f",
                  m_valid_a, m_data_a, m_keep_a, m_data_b, m_keep_b);
         n_fail++;
      end
      idle_take();
   endtask

   task automatic test_wrap();
      int n;
      n = 65536 - exp_cnt;
      m_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1; s_last = 1'b1; s_data = 8'(i);
         step();
         if (i == 100 || i == n - 1) begin
            n_checks++;
            if ({m_valid_a, word_cnt_a, m_data_a, m_keep_a} !==
                {1'b1, 16'(exp_cnt + i), 8'(i), 24'hEEEEEE, 4'b1000}) begin
               $display("FAIL wrap_stream i%0d got v=%b c=%h d=%h k=%b exp v=1 c=%h d=%h k=1000",
                        i, m_valid_a, word_cnt_a, m_data_a, m_keep_a, 16'(exp_cnt + i),
                        {8'(i), 24'hEEEEEE});
               n_fail++;
            end
         end
      end
      exp_cnt = 16'hFFFF;
      idle_take();
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_short_packet();
      test_single_beat();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
